// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the BCD display scanner
// Active-low segment codes are ordered {g,f,e,d,c,b,a}.
package display_pkg;
   localparam int DIGITS     = 4;
   localparam int NIBBLE_W   = 4;
   localparam int BRIGHT_MAX = 8;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - nibble to active-low 7-segment code
// Non-decimal nibbles render as a dash so corrupt counts are visible.
module seg7_decode
   import display_pkg::*;
(
   input  logic [NIBBLE_W-1:0] nibble,
   input  logic                blank,
   output logic [6:0]          seg
);

   always_comb begin
      seg = SEG_DASH;
      if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - multiplexed 4-digit common-anode MM:SS driver
// Snapshots BCD once per scan; blanking, colon and PWM brightness on registered outputs.
module bcd_display_scanner
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
)(
   input  logic        clk_in,
   input  logic        RESET,
   input  logic [16:1] BCD,
   input  logic        BLANK_LZ,
   input  logic        COLON_STEADY,
   input  logic [3:0]  BRIGHT,
   output logic [4:1]  AN,
   output logic [7:1]  SEG,
   output logic        DP
);

   localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   logic [DIV_W-1:0]    div;
   logic [1:0]          idx;
   logic [2:0]          pw;
   logic [16:1]         shadow;
   logic                col;
   logic                load_pend;

   logic                wrap;
   logic                load;
   logic [NIBBLE_W-1:0] nib;
   logic                blank_digit;
   logic [6:0]          seg_next;
   logic                an_on;
   logic [3:0]          an_next;
   logic                dp_next;

   assign wrap = (div == DIV_LAST);
   // The snapshot coincides with the idx 3->0 wrap so digit 0 sees fresh data.
   assign load = load_pend | (wrap & (idx == 2'd3));

   always_comb begin
      nib         = shadow[4:1];
      blank_digit = 1'b0;
      case (idx)
         2'd0: nib = shadow[4:1];
         2'd1: nib = shadow[8:5];
         2'd2: begin
            nib         = shadow[12:9];
            blank_digit = BLANK_LZ & (shadow[16:9] == 8'h00);
         end
         default: begin
            nib         = shadow[16:13];
            blank_digit = BLANK_LZ & (shadow[16:13] == 4'h0);
         end
      endcase
   end

   seg7_decode u_decode (
      .nibble (nib),
      .blank  (blank_digit),
      .seg    (seg_next)
   );

   assign an_on   = (BRIGHT >= 4'(BRIGHT_MAX)) | ({1'b0, pw} < BRIGHT);
   assign an_next = an_on ? ~(4'b0001 << idx) : 4'hF;
   assign dp_next = ~((idx == 2'd2) & col);

   always_ff @(posedge clk_in or posedge RESET) begin
      if (RESET) begin
         div       <= '0;
         idx       <= 2'd0;
         pw        <= 3'd0;
         shadow    <= 16'h0000;
         col       <= 1'b0;
         load_pend <= 1'b1;
         AN        <= 4'hF;
         SEG       <= SEG_BLANK;
         DP        <= 1'b1;
      end else begin
         div       <= wrap ? '0 : div + 1'b1;
         if (wrap) idx <= idx + 2'd1;
         pw        <= pw + 3'd1;
         load_pend <= 1'b0;
         if (load) shadow <= BCD;
         if (COLON_STEADY)
            col <= 1'b1;
         else if (load && (BCD[4:1] != shadow[4:1]))
            col <= ~col;
         AN  <= an_next;
         SEG <= seg_next;
         DP  <= dp_next;
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - self-checking bench for bcd_display_scanner
// Table vectors, hand sequences and a cycle-count reference model.
module tb_bcd_display_scanner;
   localparam int R = 4;

   logic        clk_in = 1'b0;
   logic        RESET  = 1'b1;
   logic [15:0] BCD    = 16'h0000;
   logic        BLANK_LZ = 1'b0;
   logic        COLON_STEADY = 1'b0;
   logic [3:0]  BRIGHT = 4'd8;
   logic [3:0]  AN;
   logic [6:0]  SEG;
   logic        DP;

   int n_pass = 0;
   int n_total = 0;

   // Reference model state: edges since reset release, snapshot, colon.
   int          m_c;
   logic [15:0] m_sh;
   bit          m_col;
   bit          m_first;

   bcd_display_scanner #(.REFRESH_DIV(R)) dut (
      .clk_in       (clk_in),
      .RESET        (RESET),
      .BCD          (BCD),
      .BLANK_LZ     (BLANK_LZ),
      .COLON_STEADY (COLON_STEADY),
      .BRIGHT       (BRIGHT),
      .AN           (AN),
      .SEG          (SEG),
      .DP           (DP)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [6:0] seg_of(input int n);
      case (n)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   task automatic step();
      int idx, pw, b, nib;
      bit blank, load;
      logic [6:0] e_seg;
      logic [3:0] e_an;
      logic       e_dp;
      idx   = (m_c / R) % 4;
      pw    = m_c % 8;
      nib   = int'((m_sh >> (4 * idx)) & 16'h000F);
      blank = BLANK_LZ && ((idx == 3 && m_sh[15:12] == 4'h0) || (idx == 2 && m_sh[15:8] == 8'h00));
      e_seg = blank ? 7'h7F : seg_of(nib);
      b     = (int'(BRIGHT) > 8) ? 8 : int'(BRIGHT);
      e_an  = (pw < b) ? 4'(15 ^ (1 << idx)) : 4'hF;
      e_dp  = !(idx == 2 && m_col);
      @(posedge clk_in);
      #1;
      chk("model_an", 32'(AN), 32'(e_an));
      chk("model_seg", 32'(SEG), 32'(e_seg));
      chk("model_dp", 32'(DP), 32'(e_dp));
      load = m_first || ((m_c % (4 * R)) == 4 * R - 1);
      if (COLON_STEADY) m_col = 1'b1;
      else if (load && BCD[3:0] != m_sh[3:0]) m_col = !m_col;
      if (load) m_sh = BCD;
      m_first = 1'b0;
      m_c++;
   endtask

   // Asserts reset away from the clock edge and checks the asynchronous response.
   task automatic do_reset();
      @(posedge clk_in);
      #2;
      RESET = 1'b1;
      #1;
      chk("rst_an", 32'(AN), 32'hF);
      chk("rst_seg", 32'(SEG), 32'h7F);
      chk("rst_dp", 32'(DP), 32'h1);
      @(posedge clk_in);
      #1;
      RESET = 1'b0;
      m_c = 0; m_sh = 16'h0000; m_col = 1'b0; m_first = 1'b1;
   endtask

   typedef struct {
      logic [15:0]     bcd;
      bit              blz;
      logic [3:0][6:0] seg;
   } vec_t;

   vec_t vecs[7];
   logic [3:0][3:0] an_tab;
   int cnt;

   initial begin
      an_tab  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
      vecs[0] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
      vecs[1] = '{16'h0059, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h10}};
      vecs[2] = '{16'h0059, 1'b0, {7'h40, 7'h40, 7'h12, 7'h10}};
      vecs[3] = '{16'h0509, 1'b1, {7'h7F, 7'h12, 7'h40, 7'h10}};
      vecs[4] = '{16'hC0C7, 1'b0, {7'h3F, 7'h40, 7'h3F, 7'h78}};
      vecs[5] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h40, 7'h40}};
      vecs[6] = '{16'hF9A8, 1'b0, {7'h3F, 7'h10, 7'h3F, 7'h00}};

      for (int i = 0; i < 7; i++) begin
         BCD = vecs[i].bcd; BLANK_LZ = vecs[i].blz; BRIGHT = 4'd8; COLON_STEADY = 1'b0;
         do_reset();
         for (int e = 1; e <= 16; e++) begin
            step();
            if (e % 4 == 0) begin
               chk("tbl_seg", 32'(SEG), 32'(vecs[i].seg[e / 4 - 1]));
               chk("tbl_an", 32'(AN), 32'(an_tab[e / 4 - 1]));
            end
         end
      end

      // Mid-scan BCD change stays hidden until the next snapshot.
      BCD = 16'h1020; BLANK_LZ = 1'b0;
      do_reset();
      for (int e = 1; e <= 32; e++) begin
         if (e == 6) BCD = 16'h4030;
         step();
         case (e)
            12: chk("mid_old2", 32'(SEG), 32'h40);
            16: chk("mid_old3", 32'(SEG), 32'h79);
            20: chk("mid_new0", 32'(SEG), 32'h40);
            24: chk("mid_new1", 32'(SEG), 32'h30);
            28: chk("mid_new2", 32'(SEG), 32'h40);
            32: chk("mid_new3", 32'(SEG), 32'h19);
            default: ;
         endcase
      end

      // Colon toggles only when the seconds digit changes at a snapshot.
      BCD = 16'h0000; COLON_STEADY = 1'b0;
      do_reset();
      for (int e = 1; e <= 60; e++) begin
         if (e == 14) BCD = 16'h0001;
         if (e == 30) BCD = 16'h0002;
         if (e == 48) COLON_STEADY = 1'b1;
         step();
         case (e)
            12: chk("colon_scan1", 32'(DP), 32'h1);
            28: chk("colon_scan2", 32'(DP), 32'h0);
            44: chk("colon_scan3", 32'(DP), 32'h1);
            60: chk("colon_steady", 32'(DP), 32'h0);
            default: ;
         endcase
      end

      // PWM duty counted over whole pw periods.
      BCD = 16'h1234; COLON_STEADY = 1'b0; BRIGHT = 4'd3;
      do_reset();
      cnt = 0;
      for (int e = 0; e < 8; e++) begin step(); if (AN != 4'hF) cnt++; end
      chk("pwm_bright3", 32'(cnt), 32'd3);
      BRIGHT = 4'd0; step();
      cnt = 0;
      for (int e = 0; e < 16; e++) begin step(); if (AN != 4'hF) cnt++; end
      chk("pwm_bright0", 32'(cnt), 32'd0);
      BRIGHT = 4'd15; step();
      cnt = 0;
      for (int e = 0; e < 8; e++) begin step(); if (AN != 4'hF) cnt++; end
      chk("pwm_bright15", 32'(cnt), 32'd8);

      // Randomized run against the model; reset at the end lands mid-slot.
      do_reset();
      for (int e = 0; e < 800; e++) begin
         if ($urandom_range(0, 9) == 0)
            BCD = ($urandom_range(0, 1) == 0) ? 16'($urandom) :
                  {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                   4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
         if ($urandom_range(0, 15) == 0) BRIGHT = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) BLANK_LZ = ~BLANK_LZ;
         if ($urandom_range(0, 29) == 0) COLON_STEADY = ~COLON_STEADY;
         step();
      end
      BRIGHT = 4'd8;
      repeat (6) step();
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
